// File: rtl/sata_rx_link_decode_if.sv
// Receive-side link bundle: raw dwords from the GTX wrapper in, decoded primitives
// and descrambled FIS payload out. The decoder uses the slave view.
interface sata_rx_link_decode_if;
  logic [31:0] rxdata;
  logic        rxdatak;
  logic [4:0]  prim_code;
  logic        prim_valid;
  logic [31:0] fis_data;
  logic        fis_valid;
  logic        fis_sof;
  logic        fis_end;
  logic        crc_ok;
  logic        fis_abort;

  modport master (
    output rxdata, rxdatak,
    input  prim_code, prim_valid, fis_data, fis_valid, fis_sof, fis_end, crc_ok, fis_abort
  );

  modport slave (
    input  rxdata, rxdatak,
    output prim_code, prim_valid, fis_data, fis_valid, fis_sof, fis_end, crc_ok, fis_abort
  );
endinterface

// File: rtl/sata_rx_link_decode.sv
// SATA link-layer receive decoder: primitive decode with CONT suppression, frame
// tracking, payload descrambling, one-dword hold to strip the CRC, CRC-32 check.
module sata_rx_link_decode #(
  parameter int C_MAX_DWORDS = 2049
) (
  input  logic                 clk_75m,
  input  logic                 host_rst,
  input  logic                 link_up,
  sata_rx_link_decode_if.slave rx
);
  localparam int               CNT_W    = $clog2(C_MAX_DWORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(C_MAX_DWORDS);
  localparam logic [31:0]      CRC_INIT = 32'h52325032;
  localparam logic [31:0]      CRC_POLY = 32'h04C11DB7;

  localparam logic [4:0] P_NONE  = 5'd0,  P_ALIGN = 5'd1,  P_SYNC  = 5'd2,  P_X_RDY = 5'd3;
  localparam logic [4:0] P_R_RDY = 5'd4,  P_SOF   = 5'd5,  P_EOF   = 5'd6,  P_HOLD  = 5'd7;
  localparam logic [4:0] P_HOLDA = 5'd8,  P_R_IP  = 5'd9,  P_R_OK  = 5'd10, P_R_ERR = 5'd11;
  localparam logic [4:0] P_WTRM  = 5'd12, P_DMAT  = 5'd13, P_CONT  = 5'd14, P_UNKNOWN = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_CONT} state_t;

  // Galois form of x^16+x^15+x^13+x^4+1; mask bit i is the LFSR MSB before step i.
  function automatic logic [47:0] scramble32(input logic [15:0] seed);
    logic [15:0] s;
    logic [31:0] w;
    s = seed;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      w[i] = s[15];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'hA011 : 16'h0000);
    end
    return {s, w};
  endfunction

  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  state_t           state_reg, state_next;
  logic [4:0]       k_code;
  logic             is_k, k_live, in_frame;
  logic             evt_start, evt_restart, evt_eof, evt_kill, evt_cont;
  logic             evt_data, evt_data_ok, cnt_ovf;
  logic [47:0]      scr;
  logic [31:0]      desc;

  logic [15:0]      lfsr_reg, lfsr_next;
  logic [31:0]      crc_reg, crc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      hold_reg, hold_next;
  logic             hold_valid_reg, hold_valid_next;
  logic             first_reg, first_next;
  logic [4:0]       prim_mem_reg, prim_mem_next;
  logic             cont_reg, cont_next;

  logic [4:0]       prim_code_reg, prim_code_next;
  logic             prim_valid_reg, prim_valid_next;
  logic [31:0]      fis_data_reg, fis_data_next;
  logic             fis_valid_reg, fis_valid_next;
  logic             fis_sof_reg, fis_sof_next;
  logic             fis_end_reg, fis_end_next;
  logic             crc_ok_reg, crc_ok_next;
  logic             fis_abort_reg, fis_abort_next;

  always_comb begin
    case (rx.rxdata)
      32'h7B4A4ABC: k_code = P_ALIGN;
      32'hB5B5957C: k_code = P_SYNC;
      32'h5757B57C: k_code = P_X_RDY;
      32'h4A4A957C: k_code = P_R_RDY;
      32'h3737B57C: k_code = P_SOF;
      32'hD5D5B57C: k_code = P_EOF;
      32'hD5D5AA7C: k_code = P_HOLD;
      32'h9595AA7C: k_code = P_HOLDA;
      32'h5555B57C: k_code = P_R_IP;
      32'h3535B57C: k_code = P_R_OK;
      32'h5656B57C: k_code = P_R_ERR;
      32'h5858B57C: k_code = P_WTRM;
      32'h3636B57C: k_code = P_DMAT;
      32'h9999AA7C: k_code = P_CONT;
      default:      k_code = P_UNKNOWN;
    endcase
  end

  // In CONT_IN_FRAME only a non-ALIGN K dword is acted on; junk and ALIGN fall through.
  assign is_k        = rx.rxdatak;
  assign k_live      = is_k && (k_code != P_ALIGN);
  assign in_frame    = (state_reg == S_FRAME) || ((state_reg == S_CONT) && k_live);
  assign evt_data    = (state_reg == S_FRAME) && !is_k;
  assign cnt_ovf     = evt_data && (count_reg == CNT_MAX);
  assign evt_data_ok = evt_data && !cnt_ovf;
  assign evt_start   = (state_reg == S_IDLE) && is_k && (k_code == P_SOF);
  assign evt_restart = in_frame && is_k && (k_code == P_SOF);
  assign evt_eof     = in_frame && is_k && (k_code == P_EOF);
  assign evt_kill    = in_frame && is_k &&
                       ((k_code == P_DMAT) || (k_code == P_SYNC) || (k_code == P_UNKNOWN));
  assign evt_cont    = in_frame && is_k && (k_code == P_CONT);
  assign scr         = scramble32(lfsr_reg);
  assign desc        = rx.rxdata ^ scr[31:0];

  always_ff @(posedge clk_75m) begin
    if (host_rst || !link_up) state_reg <= S_IDLE;
    else                      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (evt_start) state_next = S_FRAME;
      default: begin
        if (evt_eof || evt_kill || cnt_ovf) state_next = S_IDLE;
        else if (evt_cont)                  state_next = S_CONT;
        else if (in_frame)                  state_next = S_FRAME;
      end
    endcase
  end

  always_comb begin
    lfsr_next       = lfsr_reg;
    crc_next        = crc_reg;
    count_next      = count_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    first_next      = first_reg;
    prim_mem_next   = prim_mem_reg;
    cont_next       = cont_reg;
    prim_code_next  = P_NONE;
    prim_valid_next = 1'b0;
    fis_data_next   = '0;
    fis_valid_next  = 1'b0;
    fis_sof_next    = 1'b0;
    fis_end_next    = 1'b0;
    crc_ok_next     = 1'b0;
    fis_abort_next  = 1'b0;

    if (is_k) begin
      prim_valid_next = 1'b1;
      if (k_code == P_ALIGN) begin
        prim_code_next = P_ALIGN;
      end else if (k_code == P_CONT) begin
        cont_next      = 1'b1;
        prim_code_next = (prim_mem_reg != P_NONE) ? prim_mem_reg : P_CONT;
      end else begin
        prim_code_next = k_code;
        prim_mem_next  = k_code;
        cont_next      = 1'b0;
      end
    end else if (cont_reg) begin
      prim_valid_next = 1'b1;
      prim_code_next  = (prim_mem_reg != P_NONE) ? prim_mem_reg : P_CONT;
    end

    if (evt_start || evt_restart) begin
      lfsr_next       = 16'hFFFF;
      crc_next        = CRC_INIT;
      count_next      = '0;
      hold_valid_next = 1'b0;
      first_next      = 1'b1;
    end
    if (evt_restart || evt_kill || cnt_ovf) fis_abort_next = 1'b1;
    if (evt_kill || cnt_ovf)                hold_valid_next = 1'b0;

    // The dword just received is only held; the previous one is released.
    if (evt_data_ok) begin
      lfsr_next       = scr[47:32];
      crc_next        = crc32_step(crc_reg, desc);
      count_next      = count_reg + CNT_W'(1);
      hold_next       = desc;
      hold_valid_next = 1'b1;
      if (hold_valid_reg) begin
        fis_data_next  = hold_reg;
        fis_valid_next = 1'b1;
        fis_sof_next   = first_reg;
        first_next     = 1'b0;
      end
    end

    if (evt_eof) begin
      fis_end_next    = 1'b1;
      crc_ok_next     = (count_reg != '0) && (crc_reg == 32'h0);
      hold_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_75m) begin
    if (host_rst || !link_up) begin
      lfsr_reg       <= 16'hFFFF;
      crc_reg        <= CRC_INIT;
      count_reg      <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      first_reg      <= 1'b0;
      prim_mem_reg   <= P_NONE;
      cont_reg       <= 1'b0;
      prim_code_reg  <= P_NONE;
      prim_valid_reg <= 1'b0;
      fis_data_reg   <= '0;
      fis_valid_reg  <= 1'b0;
      fis_sof_reg    <= 1'b0;
      fis_end_reg    <= 1'b0;
      crc_ok_reg     <= 1'b0;
      fis_abort_reg  <= 1'b0;
    end else begin
      lfsr_reg       <= lfsr_next;
      crc_reg        <= crc_next;
      count_reg      <= count_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      first_reg      <= first_next;
      prim_mem_reg   <= prim_mem_next;
      cont_reg       <= cont_next;
      prim_code_reg  <= prim_code_next;
      prim_valid_reg <= prim_valid_next;
      fis_data_reg   <= fis_data_next;
      fis_valid_reg  <= fis_valid_next;
      fis_sof_reg    <= fis_sof_next;
      fis_end_reg    <= fis_end_next;
      crc_ok_reg     <= crc_ok_next;
      fis_abort_reg  <= fis_abort_next;
    end
  end

  assign rx.prim_code  = prim_code_reg;
  assign rx.prim_valid = prim_valid_reg;
  assign rx.fis_data   = fis_data_reg;
  assign rx.fis_valid  = fis_valid_reg;
  assign rx.fis_sof    = fis_sof_reg;
  assign rx.fis_end    = fis_end_reg;
  assign rx.crc_ok     = crc_ok_reg;
  assign rx.fis_abort  = fis_abort_reg;
endmodule

// File: tb/tb_sata_rx_link_decode.sv
// Self-checking bench: primitive decode table, then framed traffic checked through a
// scoreboard of expected payload words, frame ends and aborts.
module tb_sata_rx_link_decode;
  localparam int C_MAX = 16;

  localparam logic [31:0] K_ALIGN = 32'h7B4A4ABC, K_SYNC  = 32'hB5B5957C, K_X_RDY = 32'h5757B57C;
  localparam logic [31:0] K_R_RDY = 32'h4A4A957C, K_SOF   = 32'h3737B57C, K_EOF   = 32'hD5D5B57C;
  localparam logic [31:0] K_HOLD  = 32'hD5D5AA7C, K_HOLDA = 32'h9595AA7C, K_R_IP  = 32'h5555B57C;
  localparam logic [31:0] K_R_OK  = 32'h3535B57C, K_R_ERR = 32'h5656B57C, K_WTRM  = 32'h5858B57C;
  localparam logic [31:0] K_DMAT  = 32'h3636B57C, K_CONT  = 32'h9999AA7C;

  typedef struct {
    logic [31:0] d;
    logic        k;
    logic [4:0]  code;
    logic        valid;
  } pvec_t;

  typedef struct {
    logic [31:0] data;
    logic        sof;
  } fis_exp_t;

  logic clk_75m = 1'b0;
  logic host_rst = 1'b1;
  logic link_up = 1'b1;
  always #5 clk_75m = ~clk_75m;

  sata_rx_link_decode_if bus();

  sata_rx_link_decode #(.C_MAX_DWORDS(C_MAX)) dut (
    .clk_75m  (clk_75m),
    .host_rst (host_rst),
    .link_up  (link_up),
    .rx       (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  fis_exp_t    fis_q[$];
  bit          end_q[$];
  int          abort_pending = 0;
  logic [15:0] tb_lfsr;
  logic [31:0] tb_crc;
  logic [31:0] pay[20];
  pvec_t       pv[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every negedge: compare whatever the DUT produced against the scoreboard.
  task automatic wait_edge();
    fis_exp_t e;
    bit       eok;
    @(negedge clk_75m);
    if (bus.fis_valid) begin
      if (fis_q.size() == 0) chk("fis_valid_extra", 64'(bus.fis_valid), 64'h0);
      else begin
        e = fis_q.pop_front();
        chk("fis_data", 64'(bus.fis_data), 64'(e.data));
        chk("fis_sof", 64'(bus.fis_sof), 64'(e.sof));
      end
    end
    if (bus.fis_end) begin
      if (end_q.size() == 0) chk("fis_end_extra", 64'(bus.fis_end), 64'h0);
      else begin
        eok = end_q.pop_front();
        chk("crc_ok", 64'(bus.crc_ok), 64'(eok));
      end
    end
    if (bus.fis_abort) begin
      if (abort_pending == 0) chk("fis_abort_extra", 64'(bus.fis_abort), 64'h0);
      else begin
        abort_pending--;
        chk("abort_without_end", 64'(bus.fis_end), 64'h0);
      end
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic k);
    bus.rxdata  = d;
    bus.rxdatak = k;
  endtask

  task automatic cycle(input logic [31:0] d, input logic k);
    wait_edge();
    drive(d, k);
  endtask

  task automatic scr_next(output logic [31:0] m);
    logic fb;
    for (int i = 0; i < 32; i++) begin
      fb      = tb_lfsr[15];
      m[i]    = fb;
      tb_lfsr = {tb_lfsr[14:0], fb} ^ ({16{fb}} & 16'hA010);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [31:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int b = 31; b >= 0; b--) begin
      fb = c[31] ^ d[b];
      c  = c << 1;
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction

  task automatic tx_sof();
    tb_lfsr = 16'hFFFF;
    tb_crc  = 32'h52325032;
    cycle(K_SOF, 1'b1);
  endtask

  task automatic tx_word(input logic [31:0] plain, input logic [31:0] flip, input bit push, input bit sof);
    logic [31:0] m;
    scr_next(m);
    tb_crc = crc_upd(tb_crc, plain);
    if (push) fis_q.push_back('{data: plain ^ flip, sof: sof});
    cycle(plain ^ m ^ flip, 1'b0);
  endtask

  task automatic tx_crc();
    tx_word(tb_crc, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int n, input int flip_idx, input logic [31:0] flip, input bit ok);
    tx_sof();
    for (int i = 0; i < n; i++) tx_word(pay[i], (i == flip_idx) ? flip : 32'h0, 1'b1, i == 0);
    tx_crc();
    end_q.push_back(ok);
    cycle(K_EOF, 1'b1);
  endtask

  task automatic drain(input string name);
    repeat (3) cycle(32'h0, 1'b0);
    chk(name, 64'(fis_q.size() + end_q.size() + abort_pending), 64'h0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, 64'({bus.prim_code, bus.prim_valid, bus.fis_data, bus.fis_valid, bus.fis_sof,
                   bus.fis_end, bus.crc_ok, bus.fis_abort}), 64'h0);
  endtask

  initial begin
    drive(32'h0, 1'b0);
    for (int i = 0; i < 20; i++) pay[i] = 32'($urandom);

    pv.push_back('{K_ALIGN, 1'b1, 5'd1, 1'b1});
    pv.push_back('{K_SYNC,  1'b1, 5'd2, 1'b1});
    pv.push_back('{K_X_RDY, 1'b1, 5'd3, 1'b1});
    pv.push_back('{K_R_RDY, 1'b1, 5'd4, 1'b1});
    pv.push_back('{K_SOF,   1'b1, 5'd5, 1'b1});
    pv.push_back('{K_EOF,   1'b1, 5'd6, 1'b1});
    pv.push_back('{K_HOLD,  1'b1, 5'd7, 1'b1});
    pv.push_back('{K_HOLDA, 1'b1, 5'd8, 1'b1});
    pv.push_back('{K_R_IP,  1'b1, 5'd9, 1'b1});
    pv.push_back('{K_R_OK,  1'b1, 5'd10, 1'b1});
    pv.push_back('{K_R_ERR, 1'b1, 5'd11, 1'b1});
    pv.push_back('{K_WTRM,  1'b1, 5'd12, 1'b1});
    pv.push_back('{K_DMAT,  1'b1, 5'd13, 1'b1});
    pv.push_back('{32'hDEADBE7C, 1'b1, 5'd31, 1'b1});
    pv.push_back('{32'h12345678, 1'b0, 5'd0, 1'b0});
    pv.push_back('{K_SYNC,  1'b1, 5'd2, 1'b1});
    pv.push_back('{K_CONT,  1'b1, 5'd2, 1'b1});
    pv.push_back('{32'hA5A5A5A5, 1'b0, 5'd2, 1'b1});
    pv.push_back('{32'h3737B57C, 1'b0, 5'd2, 1'b1});
    pv.push_back('{32'h00000000, 1'b0, 5'd2, 1'b1});
    pv.push_back('{32'hFFFFFFFF, 1'b0, 5'd2, 1'b1});
    pv.push_back('{32'h0BADF00D, 1'b0, 5'd2, 1'b1});
    pv.push_back('{K_X_RDY, 1'b1, 5'd3, 1'b1});
    pv.push_back('{K_R_IP,  1'b1, 5'd9, 1'b1});
    pv.push_back('{K_CONT,  1'b1, 5'd9, 1'b1});
    pv.push_back('{32'h13579BDF, 1'b0, 5'd9, 1'b1});
    pv.push_back('{K_ALIGN, 1'b1, 5'd1, 1'b1});
    pv.push_back('{32'h2468ACE0, 1'b0, 5'd9, 1'b1});
    pv.push_back('{K_HOLD,  1'b1, 5'd7, 1'b1});
    pv.push_back('{32'h12345A5A, 1'b1, 5'd31, 1'b1});
    pv.push_back('{32'hCAFEBABE, 1'b0, 5'd0, 1'b0});

    repeat (3) cycle(32'h0, 1'b0);
    wait_edge();
    chk_zero("reset_outputs");
    host_rst = 1'b0;

    // SOF,EOF inside the table is an empty frame: fis_end with crc_ok=0.
    end_q.push_back(1'b0);
    for (int i = 0; i <= pv.size(); i++) begin
      wait_edge();
      if (i > 0) chk($sformatf("prim[%0d]", i - 1), 64'({bus.prim_valid, bus.prim_code}),
                     64'({pv[i-1].valid, pv[i-1].code}));
      if (i < pv.size()) drive(pv[i].d, pv[i].k);
      else               drive(32'h0, 1'b0);
    end
    drain("prim_table_drain");

    send_frame(5, -1, 32'h0, 1'b1);
    drain("good_frame");
    send_frame(5, 2, 32'h00000080, 1'b0);
    drain("bit_flip_frame");

    tx_sof();
    for (int i = 0; i < 3; i++) tx_word(pay[i], 32'h0, 1'b1, i == 0);
    cycle(K_HOLD, 1'b1);
    cycle(K_CONT, 1'b1);
    repeat (4) cycle(32'($urandom), 1'b0);
    cycle(K_HOLD, 1'b1);
    cycle(K_ALIGN, 1'b1);
    for (int i = 3; i < 5; i++) tx_word(pay[i], 32'h0, 1'b1, 1'b0);
    tx_crc();
    end_q.push_back(1'b1);
    cycle(K_EOF, 1'b1);
    drain("hold_cont_frame");

    cycle(K_SOF, 1'b1);
    end_q.push_back(1'b0);
    cycle(K_EOF, 1'b1);
    drain("empty_frame");

    // Only a CRC dword: CRC of nothing is the init value, scrambled by the first mask.
    cycle(K_SOF, 1'b1);
    cycle(32'h90E026BF, 1'b0);
    end_q.push_back(1'b1);
    cycle(K_EOF, 1'b1);
    drain("crc_only_frame");

    tx_sof();
    for (int i = 0; i < 10; i++) tx_word(pay[i], 32'h0, i < 9, i == 0);
    abort_pending++;
    cycle(K_DMAT, 1'b1);
    cycle(32'h11111111, 1'b0);
    cycle(K_EOF, 1'b1);
    drain("dmat_abort");

    tx_sof();
    for (int i = 0; i < C_MAX; i++) tx_word(pay[i], 32'h0, i < C_MAX - 1, i == 0);
    abort_pending++;
    tx_word(pay[C_MAX], 32'h0, 1'b0, 1'b0);
    cycle(K_EOF, 1'b1);
    drain("overflow_abort");

    send_frame(C_MAX - 1, -1, 32'h0, 1'b1);
    drain("max_length_frame");

    tx_sof();
    for (int i = 0; i < 3; i++) tx_word(pay[i], 32'h0, i < 2, i == 0);
    abort_pending++;
    send_frame(2, -1, 32'h0, 1'b1);
    drain("sof_restart");

    tx_sof();
    for (int i = 0; i < 4; i++) tx_word(pay[i], 32'h0, i < 3, i == 0);
    wait_edge();
    host_rst = 1'b1;
    drive(32'h0, 1'b0);
    wait_edge();
    chk_zero("mid_frame_reset_outputs");
    host_rst = 1'b0;
    send_frame(4, -1, 32'h0, 1'b1);
    drain("frame_after_reset");

    tx_sof();
    for (int i = 0; i < 2; i++) tx_word(pay[i], 32'h0, i < 1, i == 0);
    wait_edge();
    link_up = 1'b0;
    drive(32'h0, 1'b0);
    wait_edge();
    chk_zero("link_down_outputs");
    link_up = 1'b1;
    send_frame(3, -1, 32'h0, 1'b1);
    drain("frame_after_link_down");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sata_rx_link_decode.md
SATA_RX_LINK_DECODE -- requirements
Module: sata_rx_link_decode

Interface
REQ-001 Parameter C_MAX_DWORDS, default 2049, maximum scrambled data dwords per frame between SOF and EOF, CRC dword included.
REQ-002 clk_75m  input  1  phy clock, same as phyclk0/phyclk1; all logic on its rising edge.
REQ-003 host_rst  input  1  synchronous, active-high reset.
REQ-004 link_up  input  1  link established; low forces the idle state.
REQ-005 rxdata  input  32  received dword from the GTX wrapper (rxdata0/rxdata1); byte0 = rxdata[7:0].
REQ-006 rxdatak  input  1  byte0 of rxdata is a K character.
REQ-007 prim_code  output  5  current decoded primitive (encoding in REQ-012).
REQ-008 prim_valid  output  1  prim_code is valid this cycle.
REQ-009 fis_data  output  32  descrambled payload dword.
REQ-010 fis_valid / fis_sof  output  1 each  payload dword valid / first payload dword of frame.
REQ-011 fis_end / crc_ok / fis_abort  output  1 each  frame-end pulse / CRC result qualified by fis_end / frame-dropped pulse.

Function
REQ-012 Primitive decode when rxdatak=1 and rxdata[7:0]=0x7C or 0xBC (byte 0 is K): ALIGN 0x7B4A4ABC=1, SYNC 0xB5B5957C=2, X_RDY 0x5757B57C=3, R_RDY 0x4A4A957C=4, SOF 0x3737B57C=5, EOF 0xD5D5B57C=6, HOLD 0xD5D5AA7C=7, HOLDA 0x9595AA7C=8, R_IP 0x5555B57C=9, R_OK 0x3535B57C=10, R_ERR 0x5656B57C=11, WTRM 0x5858B57C=12, DMAT 0x3636B57C=13, CONT 0x9999AA7C=14; any other K dword = 31 (UNKNOWN).
REQ-013 prim_code/prim_valid registered; latency 1 cycle from input.
REQ-014 ALIGN: prim_code=1 for that cycle only; it does not alter the remembered primitive and does not end a CONT run.
REQ-015 CONT: prim_code keeps the last non-ALIGN, non-CONT primitive; subsequent non-K dwords are junk, are ignored, and keep the repeated primitive valid until the next non-ALIGN K dword.
REQ-016 Frame FSM states: IDLE, FRAME, CONT_IN_FRAME. IDLE->FRAME on SOF; FRAME->IDLE on EOF, DMAT, SYNC, UNKNOWN, or overflow; FRAME->CONT_IN_FRAME on CONT; CONT_IN_FRAME->FRAME on any non-ALIGN K dword, which is then processed normally.
REQ-017 In FRAME, ALIGN, HOLD, HOLDA, R_IP and WTRM do not end the frame, produce no payload, and do not advance the descrambler.
REQ-018 Descrambler: LFSR x^16+x^15+x^13+x^4+1, seeded 0xFFFF on SOF; advances 32 bits per non-K dword in FRAME only. First data dword after SOF XORs with 0xC2D2768D.
REQ-019 One-dword hold: each descrambled dword enters a holding register; the previously held dword is emitted on fis_data with fis_valid=1. The held dword at EOF is the CRC and is never emitted. Payload latency = 1 data dword + 1 cycle.
REQ-020 fis_sof=1 on the first emitted dword of a frame only.
REQ-021 CRC-32: poly 0x04C11DB7, non-reflected, MSB first, init 0x52325032, over every descrambled dword including the CRC dword; crc_ok=1 iff residue = 0x00000000.
REQ-022 EOF: fis_end pulses 1 cycle with crc_ok valid the same cycle. Frame with 0 data dwords (SOF then EOF): fis_end=1, crc_ok=0. Frame with only a CRC dword: no fis_valid; fis_end=1 with the CRC check applied.
REQ-023 Abort (SOF, DMAT, SYNC or UNKNOWN while in FRAME/CONT_IN_FRAME, or count > C_MAX_DWORDS): fis_abort pulses 1 cycle, held dword discarded, no fis_end. SOF-abort restarts the frame: LFSR, CRC and count reinitialise the same cycle.
REQ-024 Non-K dwords in IDLE (outside CONT) are ignored; no payload is emitted.
REQ-025 Data dword and EOF are never simultaneous (one dword per cycle); EOF on cycle n gives fis_end on cycle n+1.

Reset
REQ-026 host_rst=1 or link_up=0: FSM=IDLE, LFSR=0xFFFF, CRC=init, count=0, hold register empty, remembered primitive cleared; all outputs 0 the next cycle; an in-progress frame is dropped without fis_abort.

Verification
REQ-027 SYNC,CONT,junk x5,X_RDY -> prim_code=2 for 7 cycles, then 3; prim_valid stays 1.
REQ-028 SOF, 5 payload dwords scrambled, correct CRC, EOF -> 5 fis_valid, fis_sof on the first, fis_end=1 with crc_ok=1; first output word = raw ^ 0xC2D2768D descrambled back to the original.
REQ-029 Same frame with one payload bit flipped -> fis_end=1, crc_ok=0.
REQ-030 SOF, 3 data, HOLD,CONT,junk x4,HOLD, ALIGN, 2 data, CRC, EOF -> 5 payload dwords match, crc_ok=1, junk not emitted, LFSR unaffected by junk and ALIGN.
REQ-031 SOF, 10 data, DMAT -> fis_abort=1 one cycle, no fis_end, FSM IDLE; C_MAX_DWORDS+1 data dwords -> fis_abort.
REQ-032 host_rst=1 mid-frame after 4 data dwords -> outputs 0 next cycle; a following complete frame decodes with crc_ok=1.
